// File: rtl/calyx_fsm_pkg.sv
// calyx_fsm_pkg: shared state encoding and limits for the calyx FSM controllers
package calyx_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } par_state_e;

    localparam int FSM_PAR_MAX_CHILD = 16;

endpackage

// File: rtl/fsm_wdog.sv
// fsm_wdog: run-length watchdog; counts enabled cycles and flags the limit cycle
//  clk     in   clock
//  reset   in   async active-high reset
//  clr     in   synchronous clear of the count
//  en      in   count this cycle
//  expire  out  high while en=1 and count == LIMIT-1
module fsm_wdog #(
    parameter int W     = 16,
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expire = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/fsm_par_ctrl.sv
// fsm_par_ctrl: fans one go request out to N children and returns ready once all are done
//  clk          in   clock
//  reset        in   async active-high reset
//  valid        in   go request from the parent
//  ready        out  all children done; held until valid drops
//  valid_child  out  per-child go, cleared per child once its done is latched
//  ready_child  in   per-child done
//  err          out  watchdog expired, sticky until reset
//  Optional watchdog: define FSM_PAR_WDOG_EN to enable the RUN-length limit and ERR state.
module fsm_par_ctrl
    import calyx_fsm_pkg::*;
#(
    parameter int N_CHILD    = 4,
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    output logic               ready,
    output logic [N_CHILD-1:0] valid_child,
    input  logic [N_CHILD-1:0] ready_child,
    output logic               err
);

    if (N_CHILD < 1 || N_CHILD > FSM_PAR_MAX_CHILD || WDOG_W < 1 || WDOG_LIMIT < 1)
        $error("fsm_par_ctrl: parameter out of range");

    par_state_e         state_q, state_d;
    logic [N_CHILD-1:0] done_mask;
    logic               all_done;
    logic               wdog_expire;

    // Same-cycle dones count toward completion without waiting for the latch.
    assign all_done = &(done_mask | ready_child);

`ifdef FSM_PAR_WDOG_EN
    fsm_wdog #(.W(WDOG_W), .LIMIT(WDOG_LIMIT)) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q == IDLE && valid),
        .en     (state_q == RUN),
        .expire (wdog_expire)
    );
    assign err = (state_q == ERR);
`else
    assign wdog_expire = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            done_mask <= '0;
        end else begin
            state_q   <= state_d;
            // Outside RUN the mask is held clear so every run starts fresh.
            done_mask <= (state_q == RUN) ? (done_mask | ready_child) : '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        valid_child = '0;
        case (state_q)
            IDLE: state_d = valid ? RUN : IDLE;
            RUN: begin
                valid_child = ~done_mask;
                // Completion on the limit cycle takes priority over expiry.
                state_d = all_done ? DONE : (wdog_expire ? ERR : RUN);
            end
            DONE: begin
                ready   = 1'b1;
                state_d = valid ? DONE : IDLE;
            end
            default: state_d = ERR;
        endcase
    end

endmodule

// File: tb/tb_fsm_par_ctrl.sv
// tb_fsm_par_ctrl: random and directed checks of fsm_par_ctrl against a protocol-level model
module tb_fsm_par_ctrl;

    localparam int N   = 4;
    localparam int LIM = 8;
`ifdef FSM_PAR_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid = 1'b0;
    logic         ready;
    logic [N-1:0] valid_child;
    logic [N-1:0] ready_child = '0;
    logic         err;

    int total = 0;
    int bad   = 0;

    fsm_par_ctrl #(.N_CHILD(N), .WDOG_W(16), .WDOG_LIMIT(LIM)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .ready       (ready),
        .valid_child (valid_child),
        .ready_child (ready_child),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Protocol model: a run is in progress, finished (awaiting valid drop), or timed out.
    bit           busy, finished, expired;
    logic [N-1:0] got;
    int           run_cycles;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy = 0; finished = 0; expired = 0; got = '0; run_cycles = 0;
        end else if (expired) begin
        end else if (finished) begin
            if (!valid) finished = 0;
        end else if (busy) begin
            run_cycles++;
            got = got | ready_child;
            if (got == {N{1'b1}}) begin
                busy = 0; finished = 1;
            end else if (WDOG && run_cycles == LIM) begin
                busy = 0; expired = 1;
            end
        end else if (valid) begin
            busy = 1; got = '0; run_cycles = 0;
        end
    end

    always @(negedge clk) begin
        logic [N+1:0] exp_v, act_v;
        exp_v = {finished, expired, busy ? ~got : {N{1'b0}}};
        act_v = {ready, err, valid_child};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL model t=%0t {ready,err,valid_child} got=%b want=%b", $time, act_v, exp_v);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [N+1:0] want);
        total++;
        if ({ready, err, valid_child} !== want) begin
            bad++;
            $display("FAIL %s {ready,err,valid_child} got=%b want=%b", name, {ready, err, valid_child}, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; valid = 1'b0; ready_child = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_state", 6'b00_0000);

        // Reset mid-RUN with done_mask=0101
        valid = 1'b1;
        tick();
        ready_child = 4'b0101;
        tick();
        ready_child = '0;
        chk("midrun_mask", 6'b00_1010);
        reset = 1'b1;
        #1;
        chk("async_reset", 6'b00_0000);
        tick();
        reset = 1'b0;
        tick();
        chk("after_reset_run", 6'b00_1111);

        // Simultaneous completion
        do_reset();
        valid = 1'b1;
        tick();
        chk("simul_c1", 6'b00_1111);
        ready_child = 4'b1111;
        tick();
        ready_child = '0;
        chk("simul_c2", 6'b10_0000);

        // Staggered completion
        do_reset();
        valid = 1'b1;
        tick();
        chk("stag_c1", 6'b00_1111);
        ready_child = 4'b0101;
        tick();
        ready_child = '0;
        chk("stag_c2", 6'b00_1010);
        tick();
        ready_child = 4'b1000;
        tick();
        ready_child = '0;
        chk("stag_c4", 6'b00_0010);
        ready_child = 4'b0010;
        tick();
        ready_child = '0;
        chk("stag_c5_done", 6'b10_0000);

        // Handshake hold
        for (int i = 0; i < 5; i++) begin
            ready_child = 4'($urandom);
            tick();
            chk("hold_ready", 6'b10_0000);
        end
        ready_child = '0;
        valid = 1'b0;
        tick();
        chk("drop_idle", 6'b00_0000);
        valid = 1'b1;
        tick();
        chk("reissue_run", 6'b00_1111);

        // Spurious ready while idle
        do_reset();
        ready_child = 4'b1111;
        tick();
        tick();
        chk("spurious_idle", 6'b00_0000);
        ready_child = '0;
        valid = 1'b1;
        tick();
        chk("spurious_run", 6'b00_1111);

`ifdef FSM_PAR_WDOG_EN
        do_reset();
        valid = 1'b1;
        tick();
        ready_child = 4'b1011;
        for (int i = 0; i < LIM; i++) begin
            chk("wdog_running", (i == 0) ? 6'b00_1111 : 6'b00_0100);
            tick();
        end
        chk("wdog_err", 6'b01_0000);
        for (int i = 0; i < 3; i++) begin
            valid = i[0];
            ready_child = 4'b1111;
            tick();
            chk("wdog_sticky", 6'b01_0000);
        end
        do_reset();
        chk("wdog_cleared", 6'b00_0000);
        valid = 1'b1;
        tick();
        ready_child = 4'b1011;
        tick();
        ready_child = '0;
        for (int i = 0; i < LIM - 2; i++) tick();
        chk("wdog_last_cycle", 6'b00_0100);
        ready_child = 4'b0100;
        tick();
        ready_child = '0;
        chk("wdog_limit_done", 6'b10_0000);
`endif

        // Random traffic checked by the model every cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            valid = ($urandom_range(0, 7) != 0);
            for (int b = 0; b < N; b++) ready_child[b] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                #1;
                chk("rand_async_reset", 6'b00_0000);
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
